// File: rtl/branch_predict_ctrl_pkg.sv
// Shared processor package: FSM encodings, counter width default and the
// Decode-stage prediction record used by the branch prediction controller.
package branch_predict_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic        valid;
        logic        pred_taken;
        logic [31:0] pred_pc;
    } dec_rec_t;

    localparam dec_rec_t DEC_REC_CLEAR = '{valid: 1'b0, pred_taken: 1'b0, pred_pc: 32'h0000_0000};

endpackage

// File: rtl/branch_predict_ctrl_sat_counter.sv
// Saturating up-counter for the branch statistics; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment unless already at the maximum value.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: picks the next Fetch PC from the BTB hint,
// checks the hint when the branch resolves in Decode and redirects on a miss.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             branchstall,
    input  logic [31:0]      PCF,
    input  logic [31:0]      PCPlus4F,
    input  logic             prediction,
    input  logic [31:0]      predictedPC,
    input  logic             predEnable,
    input  logic             isBranchD,
    input  logic             branchTakenD,
    input  logic [31:0]      branchTargetD,
    input  logic [31:0]      PCPlus4D,
    output logic [31:0]      PCNextF,
    output logic             pcEnF,
    output logic             flushD,
    output logic             mispredictD,
    output logic             btbUpdateD,
    output logic [CNT_W-1:0] branchCount,
    output logic [CNT_W-1:0] mispredictCount
);

    bp_state_e state_q;
    bp_state_e state_d;
    dec_rec_t  rec_q;
    dec_rec_t  rec_d;

    logic take_f_s;
    logic resolve_s;
    logic dir_wrong_s;
    logic tgt_wrong_s;
    logic alias_s;
    logic mispredict_s;
    logic unused_pcf_s;

    // The BTB is indexed externally; the Fetch PC itself is not needed here.
    assign unused_pcf_s = ^PCF;

    // Fetch hint qualification and Decode-stage resolution checks.
    always_comb begin
        take_f_s     = prediction & predEnable;
        resolve_s    = rec_q.valid & ~stallD & ~branchstall & (state_q == ST_RUN) & ~reset;
        dir_wrong_s  = isBranchD & (rec_q.pred_taken != branchTakenD);
        tgt_wrong_s  = isBranchD & branchTakenD & rec_q.pred_taken & (rec_q.pred_pc != branchTargetD);
        alias_s      = ~isBranchD & rec_q.pred_taken;
        mispredict_s = resolve_s & (dir_wrong_s | tgt_wrong_s | alias_s);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: a redirect occupies exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mispredict_s) begin
                    state_d = ST_REDIRECT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIRECT: state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    // FSM outputs: redirect overrides both the hint and the Fetch stall.
    always_comb begin
        flushD      = mispredict_s;
        mispredictD = mispredict_s;
        btbUpdateD  = resolve_s & isBranchD;
        pcEnF       = reset | mispredict_s | ~stallF;
        if (mispredict_s) begin
            if (isBranchD && branchTakenD) begin
                PCNextF = branchTargetD;
            end else begin
                PCNextF = PCPlus4D;
            end
        end else if (take_f_s) begin
            PCNextF = predictedPC;
        end else begin
            PCNextF = PCPlus4F;
        end
    end

    // Decode record next value: flush beats stall.
    always_comb begin
        rec_d = rec_q;
        if (mispredict_s) begin
            rec_d = DEC_REC_CLEAR;
        end else if (!stallD) begin
            rec_d = '{valid: 1'b1, pred_taken: take_f_s, pred_pc: predictedPC};
        end else begin
            rec_d = rec_q;
        end
    end

    // Decode record register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q <= DEC_REC_CLEAR;
        end else begin
            rec_q <= rec_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (btbUpdateD),
        .count (branchCount)
    );

    sat_counter #(.W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mispredictD),
        .count (mispredictCount)
    );

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: directed scenarios then random traffic,
// two instances (default and 2-bit counters) driven from the same stimulus.
module tb_branch_predict_ctrl;
    import branch_predict_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stallF, stallD, branchstall, prediction, predEnable;
    logic        isBranchD, branchTakenD;
    logic [31:0] PCF, PCPlus4F, predictedPC, branchTargetD, PCPlus4D;

    logic [31:0] pcnext_a, pcnext_b;
    logic        pcen_a, pcen_b, flush_a, flush_b, mis_a, mis_b, btb_a, btb_b;
    logic [15:0] bc_a, mc_a;
    logic [1:0]  bc_b, mc_b;

    branch_predict_ctrl dut (
        .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .branchstall(branchstall),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .prediction(prediction), .predictedPC(predictedPC),
        .predEnable(predEnable), .isBranchD(isBranchD), .branchTakenD(branchTakenD),
        .branchTargetD(branchTargetD), .PCPlus4D(PCPlus4D), .PCNextF(pcnext_a), .pcEnF(pcen_a),
        .flushD(flush_a), .mispredictD(mis_a), .btbUpdateD(btb_a),
        .branchCount(bc_a), .mispredictCount(mc_a)
    );

    branch_predict_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .branchstall(branchstall),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .prediction(prediction), .predictedPC(predictedPC),
        .predEnable(predEnable), .isBranchD(isBranchD), .branchTakenD(branchTakenD),
        .branchTargetD(branchTargetD), .PCPlus4D(PCPlus4D), .PCNextF(pcnext_b), .pcEnF(pcen_b),
        .flushD(flush_b), .mispredictD(mis_b), .btbUpdateD(btb_b),
        .branchCount(bc_b), .mispredictCount(mc_b)
    );

    typedef struct {
        logic [31:0] pcnext;
        logic        pcen, flush, mis, btb, redirect;
        int          bc16, mc16, bc2, mc2;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: what Decode holds and whether last cycle redirected.
    logic        m_valid = 1'b0, m_ptaken = 1'b0, m_redirect = 1'b0;
    logic [31:0] m_ppc = 32'h0;
    int          m_bc16 = 0, m_mc16 = 0, m_bc2 = 0, m_mc2 = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sat_add(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    // One clock cycle: predict this cycle's outputs, queue them, then advance the model.
    task automatic step();
        exp_t e;
        logic resolve, wrong, nv, np;
        logic [31:0] npc;
        resolve = !reset && m_valid && !stallD && !branchstall && !m_redirect;
        if (isBranchD)
            wrong = resolve && ((m_ptaken != branchTakenD) ||
                                (branchTakenD && m_ptaken && (m_ppc != branchTargetD)));
        else
            wrong = resolve && m_ptaken;
        if (wrong)
            e.pcnext = (isBranchD && branchTakenD) ? branchTargetD : PCPlus4D;
        else
            e.pcnext = (prediction && predEnable) ? predictedPC : PCPlus4F;
        e.pcen = wrong || reset || !stallF;
        e.flush = wrong;
        e.mis = wrong;
        e.btb = resolve && isBranchD;
        e.redirect = m_redirect;
        e.bc16 = m_bc16; e.mc16 = m_mc16; e.bc2 = m_bc2; e.mc2 = m_mc2;
        sb.push_back(e);
        nv = m_valid; np = m_ptaken; npc = m_ppc;
        if (wrong) begin
            nv = 1'b0; np = 1'b0; npc = 32'h0;
        end else if (!stallD) begin
            nv = 1'b1; np = prediction && predEnable; npc = predictedPC;
        end
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0; m_ptaken = 1'b0; m_ppc = 32'h0; m_redirect = 1'b0;
            m_bc16 = 0; m_mc16 = 0; m_bc2 = 0; m_mc2 = 0;
        end else begin
            m_valid = nv; m_ptaken = np; m_ppc = npc; m_redirect = wrong;
            if (e.btb) begin m_bc16 = sat_add(m_bc16, 65535); m_bc2 = sat_add(m_bc2, 3); end
            if (wrong) begin m_mc16 = sat_add(m_mc16, 65535); m_mc2 = sat_add(m_mc2, 3); end
        end
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; stallF = 1'b0; stallD = 1'b0; branchstall = 1'b0;
        PCF = 32'h0; PCPlus4F = 32'h4; prediction = 1'b0; predictedPC = 32'h0; predEnable = 1'b1;
        isBranchD = 1'b0; branchTakenD = 1'b0; branchTargetD = 32'h0; PCPlus4D = 32'h0;
    endtask

    // Monitor: every cycle, compare both instances against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("PCNextF", pcnext_a, e.pcnext);
            chk("pcEnF", pcen_a, e.pcen);
            chk("flushD", flush_a, e.flush);
            chk("mispredictD", mis_a, e.mis);
            chk("btbUpdateD", btb_a, e.btb);
            chk("branchCount", bc_a, e.bc16);
            chk("mispredictCount", mc_a, e.mc16);
            chk("state", (dut.state_q == ST_REDIRECT), e.redirect);
            chk("PCNextF_w2", pcnext_b, e.pcnext);
            chk("flushD_w2", flush_b, e.flush);
            chk("btbUpdateD_w2", btb_b, e.btb);
            chk("branchCount_w2", bc_b, e.bc2);
            chk("mispredictCount_w2", mc_b, e.mc2);
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        step(); step();
        chk("reset_bc", bc_a, 0);
        chk("reset_mc", mc_a, 0);
        idle();

        // Correctly predicted taken branch at 0x40 -> 0x80.
        PCF = 32'h40; PCPlus4F = 32'h44; prediction = 1'b1; predictedPC = 32'h80;
        #1 chk("hint_pcnext", pcnext_a, 32'h80);
        step();
        idle();
        isBranchD = 1'b1; branchTakenD = 1'b1; branchTargetD = 32'h80; PCPlus4D = 32'h44;
        #1 chk("hit_btb", btb_a, 1); chk("hit_flush", flush_a, 0);
        step();
        chk("hit_bc", bc_a, 1); chk("hit_mc", mc_a, 0);

        // Unhinted branch resolving taken to 0x100 while Fetch is stalled.
        idle();
        isBranchD = 1'b1; branchTakenD = 1'b1; branchTargetD = 32'h100; PCPlus4D = 32'h44; stallF = 1'b1;
        #1 chk("miss_pcnext", pcnext_a, 32'h100); chk("miss_flush", flush_a, 1); chk("miss_pcen", pcen_a, 1);
        step();
        idle();
        chk("redir_state", (dut.state_q == ST_REDIRECT), 1);
        #1 chk("redir_noflush", flush_a, 0);
        step();
        chk("run_again", (dut.state_q == ST_REDIRECT), 0);

        // Aliased hint on a non-branch.
        prediction = 1'b1; predictedPC = 32'h30;
        step();
        idle();
        PCPlus4D = 32'h24;
        #1 chk("alias_pcnext", pcnext_a, 32'h24); chk("alias_flush", flush_a, 1); chk("alias_btb", btb_a, 0);
        step();
        chk("alias_mc", mc_a, 2); chk("alias_bc", bc_a, 2);
        idle();
        step();

        // Branch operands late for 3 cycles; hint changes while held must not leak in.
        for (int i = 0; i < 3; i++) begin
            idle();
            isBranchD = 1'b1; branchstall = 1'b1; stallD = 1'b1; stallF = 1'b1;
            prediction = 1'b1; predictedPC = 32'h200;
            #1 chk("bstall_btb", btb_a, 0);
            step();
        end
        idle();
        isBranchD = 1'b1;
        #1 chk("release_btb", btb_a, 1); chk("release_flush", flush_a, 0);
        step();

        // Reset arriving during the redirect cycle.
        idle();
        isBranchD = 1'b1; branchTakenD = 1'b1; branchTargetD = 32'h300;
        step();
        idle();
        reset = 1'b1; stallF = 1'b1;
        #1 chk("rst_flush", flush_a, 0); chk("rst_pcen", pcen_a, 1); chk("rst_btb", btb_a, 0);
        step();
        idle();
        predEnable = 1'b0; prediction = 1'b1; predictedPC = 32'h500; PCPlus4F = 32'h48;
        chk("post_rst_state", (dut.state_q == ST_REDIRECT), 0);
        chk("post_rst_bc", bc_a, 0); chk("post_rst_mc", mc_a, 0);
        #1 chk("post_rst_flush", flush_a, 0); chk("pred_off_pcnext", pcnext_a, 32'h48);
        step();

        // Five mispredicts: the 2-bit counters must stick at 3.
        for (int i = 0; i < 5; i++) begin
            idle();
            isBranchD = 1'b1; branchTakenD = 1'b1; branchTargetD = 32'h600;
            step();
            idle();
            step();
        end
        chk("sat_mc_w2", mc_b, 3); chk("sat_mc_w16", mc_a, 5); chk("sat_bc_w2", bc_b, 3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            stallF       = ($urandom_range(0, 3) == 0);
            stallD       = ($urandom_range(0, 3) == 0);
            branchstall  = ($urandom_range(0, 3) == 0);
            PCF          = $urandom & 32'hFFFF_FFFC;
            PCPlus4F     = PCF + 32'h4;
            prediction   = $urandom_range(0, 1);
            predEnable   = ($urandom_range(0, 3) != 0);
            predictedPC  = 32'h100 * $urandom_range(1, 3);
            isBranchD    = $urandom_range(0, 1);
            branchTakenD = $urandom_range(0, 1);
            branchTargetD = 32'h100 * $urandom_range(1, 3);
            PCPlus4D     = $urandom & 32'hFFFF_FFFC;
            step();
        end
        idle();
        @(negedge clk); #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
